flatten_backward: RTL and testbench

//  Backward pass of the flatten layer. Un-flattens gradient tensor B into

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/tensor_hdr_reader.sv | 56 +++++
 rtl/flatten_backward.sv | 186 ++++++++++++++++++
 tb/tb_flatten_backward.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU tensor units: flatten-backward FSM states,
// dimension word type and the tensor header length.
package fpu_pkg;

    localparam int HDR_WORDS = 4;

    typedef logic [31:0] dim_t;

    typedef enum logic [3:0] {
        WAIT,
        RD_AHDR,
        RD_BHDR,
        CHECK,
        WR_HDR,
        LOAD,
        WB,
        DONE,
        ERR
    } fbw_state_t;

    // Pick dim i out of a packed 4-dim header image (dim 0 in the low word).
    function automatic dim_t dim_sel(input logic [HDR_WORDS*32-1:0] dims, input logic [1:0] i);
        return dims[{i, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/tensor_hdr_reader.sv
// Accumulates one 4-word tensor header: stores the dims, keeps a running
// unsigned 32b product and a sticky overflow flag, and supplies the next word address.
module tensor_hdr_reader
    import fpu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     cap_i,
    input  logic [AW-1:0]            base_i,
    input  dim_t                     rdata_i,
    output logic                     first_o,
    output logic                     last_o,
    output logic [AW-1:0]            next_addr_o,
    output logic [HDR_WORDS*32-1:0]  dims_o,
    output dim_t                     prod_o,
    output logic                     ovf_o
);

    logic [1:0]              cnt_q;
    logic [HDR_WORDS*32-1:0] dims_q;
    dim_t                    prod_q;
    logic                    ovf_q;
    dim_t                    acc_base;
    logic [63:0]             prod_full;

    // Capturing word 0 restarts the product, so no explicit clear is needed
    // between tensors and the previous result stays readable until then.
    always_comb begin
        acc_base  = (cnt_q == 2'd0) ? 32'd1 : prod_q;
        prod_full = {32'd0, acc_base} * {32'd0, rdata_i};
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q  <= '0;
            dims_q <= '0;
            prod_q <= '0;
            ovf_q  <= 1'b0;
        end else if (cap_i) begin
            cnt_q                       <= cnt_q + 2'd1;
            dims_q[{cnt_q, 5'b0} +: 32] <= rdata_i;
            prod_q                      <= prod_full[31:0];
            ovf_q                       <= ((cnt_q != 2'd0) & ovf_q) | (|prod_full[63:32]);
        end
    end

    assign first_o     = (cnt_q == 2'd0);
    assign last_o      = (cnt_q == 2'd3);
    assign next_addr_o = base_i + AW'({1'b0, cnt_q} + 3'd1);
    assign dims_o      = dims_q;
    assign prod_o      = prod_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/flatten_backward.sv
// Flatten backward pass: copies gradient B into D under A's 4-D header.
// Define FLATTEN_BW_SIZECHECK_EN to reject ops whose A and B element counts differ.
module flatten_backward
    import fpu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          go,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] d_base,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          done,
    output logic          err,
    output logic [3:0]    dbg_state
);

    // Memory port: req/we/addr/wdata are registered and held until the cycle
    // in which mem_ack=1; read data is taken in that same ack cycle.
    fbw_state_t              state_q;
    logic                    req_q, we_q, done_q, err_q, ovfa_q;
    logic [AW-1:0]           addr_q, a_base_q, b_base_q, d_base_q;
    logic [DW-1:0]           wdata_q;
    logic [HDR_WORDS*32-1:0] dima_q;
    dim_t                    proda_q, idx_q;
    logic [1:0]              hidx_q;

    logic                    rd_cap, rd_first, rd_last, rd_ovf, size_ok;
    logic [AW-1:0]           rd_base, rd_next_addr;
    logic [HDR_WORDS*32-1:0] rd_dims;
    dim_t                    rd_prod;
    logic [AW-1:0]           hdr_off;

    assign hdr_off = AW'(HDR_WORDS);
    assign rd_base = (state_q == RD_BHDR) ? b_base_q : a_base_q;
    assign rd_cap  = mem_ack && ((state_q == RD_AHDR) || (state_q == RD_BHDR));

    tensor_hdr_reader #(.AW(AW)) u_hdr_reader (
        .clk         (clk),
        .rst_i       (rst_l),
        .cap_i       (rd_cap),
        .base_i      (rd_base),
        .rdata_i     (dim_t'(mem_rdata)),
        .first_o     (rd_first),
        .last_o      (rd_last),
        .next_addr_o (rd_next_addr),
        .dims_o      (rd_dims),
        .prod_o      (rd_prod),
        .ovf_o       (rd_ovf)
    );

`ifdef FLATTEN_BW_SIZECHECK_EN
    assign size_ok = (proda_q == rd_prod);
`else
    assign size_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst_l) begin
            state_q  <= WAIT;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            a_base_q <= '0;
            b_base_q <= '0;
            d_base_q <= '0;
            dima_q   <= '0;
            proda_q  <= '0;
            ovfa_q   <= 1'b0;
            hidx_q   <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                WAIT: if (go) begin
                    a_base_q <= a_base;
                    b_base_q <= b_base;
                    d_base_q <= d_base;
                    req_q    <= 1'b1;
                    we_q     <= 1'b0;
                    addr_q   <= a_base;
                    state_q  <= RD_AHDR;
                end
                RD_AHDR: if (mem_ack) begin
                    if (rd_last) begin
                        addr_q  <= b_base_q;
                        state_q <= RD_BHDR;
                    end else begin
                        addr_q  <= rd_next_addr;
                    end
                end
                // The reader still holds A until B's first word lands.
                RD_BHDR: if (mem_ack) begin
                    if (rd_first) begin
                        dima_q  <= rd_dims;
                        proda_q <= rd_prod;
                        ovfa_q  <= rd_ovf;
                    end
                    if (rd_last) begin
                        req_q   <= 1'b0;
                        state_q <= CHECK;
                    end else begin
                        addr_q  <= rd_next_addr;
                    end
                end
                CHECK: begin
                    if (ovfa_q || rd_ovf || !size_ok) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= d_base_q;
                        wdata_q <= DW'(dim_sel(dima_q, 2'd0));
                        hidx_q  <= '0;
                        state_q <= WR_HDR;
                    end
                end
                WR_HDR: if (mem_ack) begin
                    if (hidx_q == 2'd3) begin
                        we_q <= 1'b0;
                        if (proda_q != '0) begin
                            idx_q   <= '0;
                            addr_q  <= b_base_q + hdr_off;
                            state_q <= LOAD;
                        end else begin
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        hidx_q  <= hidx_q + 2'd1;
                        addr_q  <= d_base_q + AW'({1'b0, hidx_q} + 3'd1);
                        wdata_q <= DW'(dim_sel(dima_q, hidx_q + 2'd1));
                    end
                end
                LOAD: if (mem_ack) begin
                    wdata_q <= mem_rdata;
                    we_q    <= 1'b1;
                    addr_q  <= d_base_q + hdr_off + AW'(idx_q);
                    state_q <= WB;
                end
                WB: if (mem_ack) begin
                    we_q <= 1'b0;
                    if (idx_q == proda_q - 32'd1) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 32'd1;
                        addr_q  <= b_base_q + hdr_off + AW'(idx_q + 32'd1);
                        state_q <= LOAD;
                    end
                end
                DONE: if (!go) begin
                    done_q  <= 1'b0;
                    state_q <= WAIT;
                end
                ERR: if (!go) begin
                    err_q   <= 1'b0;
                    state_q <= WAIT;
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_flatten_backward.sv
// Directed bench for flatten_backward: word memory model with optional
// random ack stalls, hand-computed expectations for D and op status.
module tb_flatten_backward;
  import fpu_pkg::*;

  localparam int A_B = 32'h10;
  localparam int B_B = 32'h40;
  localparam int D_B = 32'h80;
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_l, go;
  logic [31:0] a_base, b_base, d_base;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        done, err;
  logic [3:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flatten_backward dut (
    .clk(clk), .rst_l(rst_l), .go(go),
    .a_base(a_base), .b_base(b_base), .d_base(d_base),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model: ack in the request cycle once the stall count drains
  logic [31:0] mem [0:1023];
  int max_stall = 0;
  int wait_cnt  = 0;
  int wr_cnt    = 0;

  assign mem_ack   = mem_req && (wait_cnt == 0);
  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr[9:0]] = mem_wdata;
        wr_cnt = wr_cnt + 1;
      end
      wait_cnt <= int'($urandom_range(max_stall, 0));
    end else if (mem_req && wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  // a stalled request must hold its command until acked
  logic        pend = 1'b0;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  always @(negedge clk) begin
    if (pend && !rst_l) begin
      check("hold_req", mem_req, 1'b1);
      check("hold_we", mem_we, s_we);
      check("hold_addr", mem_addr, s_addr);
      check("hold_wdata", mem_wdata, s_wdata);
    end
    pend    = mem_req && !mem_ack && !rst_l;
    s_we    = mem_we;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = FILL;
  endtask

  task automatic put_hdr(input int base, input logic [31:0] d0, d1, d2, d3);
    mem[base]   = d0;
    mem[base+1] = d1;
    mem[base+2] = d2;
    mem[base+3] = d3;
  endtask

  task automatic put_bdata(input int n);
    for (int i = 0; i < n; i++) mem[B_B+4+i] = 32'(10 + i);
  endtask

  // cycles counts rising edges from the one that samples go up to the one
  // after which done/err is seen
  task automatic run_op(input bit hold_go, output int cycles);
    @(negedge clk);
    a_base = A_B;
    b_base = B_B;
    d_base = D_B;
    wr_cnt = 0;
    go     = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!(done || err) && cycles < 3000);
    check("op_finished", done || err, 1'b1);
    @(negedge clk);
    if (!hold_go) go = 1'b0;
  endtask

  task automatic check_t1_result(input string t);
    check({t, "_done"}, done, 1'b1);
    check({t, "_err"}, err, 1'b0);
    check({t, "_hdr0"}, mem[D_B],   32'd2);
    check({t, "_hdr1"}, mem[D_B+1], 32'd3);
    check({t, "_hdr2"}, mem[D_B+2], 32'd1);
    check({t, "_hdr3"}, mem[D_B+3], 32'd1);
    for (int i = 0; i < 6; i++) check($sformatf("%s_data%0d", t, i), mem[D_B+4+i], 32'(10 + i));
    check({t, "_beyond"}, mem[D_B+10], FILL);
    check({t, "_writes"}, wr_cnt, 10);
  endtask

  task automatic setup_t1();
    clear_mem();
    put_hdr(A_B, 2, 3, 1, 1);
    put_hdr(B_B, 6, 1, 1, 1);
    put_bdata(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_l  = 1'b1;
    go     = 1'b0;
    a_base = '0;
    b_base = '0;
    d_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, WAIT);
    @(negedge clk);
    rst_l = 1'b0;

    // basic un-flatten with single-cycle acks, exact latency
    setup_t1();
    run_op(1'b0, cyc);
    check("t1_cycles", cyc, 26);
    check_t1_result("t1");
    @(posedge clk);
    #1;
    check("t1_back_wait", dbg_state, WAIT);
    check("t1_done_low", done, 1'b0);

    // same op under random ack stalls
    setup_t1();
    max_stall = 5;
    run_op(1'b0, cyc);
    check_t1_result("t3");
    max_stall = 0;

    // element count mismatch: 4 in A, 5 in B
    clear_mem();
    put_hdr(A_B, 2, 2, 1, 1);
    put_hdr(B_B, 5, 1, 1, 1);
    put_bdata(5);
    run_op(1'b0, cyc);
`ifdef FLATTEN_BW_SIZECHECK_EN
    check("t4_err", err, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_writes", wr_cnt, 0);
    check("t4_hdr_untouched", mem[D_B], FILL);
`else
    check("t4_done", done, 1'b1);
    check("t4_err", err, 1'b0);
    check("t4_writes", wr_cnt, 8);
    check("t4_hdr0", mem[D_B], 32'd2);
    for (int i = 0; i < 4; i++) check($sformatf("t4_data%0d", i), mem[D_B+4+i], 32'(10 + i));
    check("t4_beyond", mem[D_B+8], FILL);
`endif

    // zero dim: header only
    clear_mem();
    put_hdr(A_B, 0, 7, 1, 1);
    put_hdr(B_B, 0, 1, 1, 1);
    run_op(1'b0, cyc);
    check("t5a_done", done, 1'b1);
    check("t5a_err", err, 1'b0);
    check("t5a_writes", wr_cnt, 4);
    check("t5a_hdr0", mem[D_B],   32'd0);
    check("t5a_hdr1", mem[D_B+1], 32'd7);
    check("t5a_hdr3", mem[D_B+3], 32'd1);
    check("t5a_no_data", mem[D_B+4], FILL);

    // 65536*65536 overflows 32 bits
    clear_mem();
    put_hdr(A_B, 65536, 65536, 1, 1);
    put_hdr(B_B, 1, 1, 1, 1);
    run_op(1'b0, cyc);
    check("t5b_err", err, 1'b1);
    check("t5b_done", done, 1'b0);
    check("t5b_writes", wr_cnt, 0);

    // reset while in LOAD, then a clean rerun with go held at DONE
    setup_t1();
    @(negedge clk);
    a_base = A_B;
    b_base = B_B;
    d_base = D_B;
    go     = 1'b1;
    for (int k = 0; k < 200 && dbg_state != LOAD; k++) @(negedge clk);
    check("t6_in_load", dbg_state, LOAD);
    rst_l = 1'b1;
    go    = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_req", mem_req, 1'b0);
    check("t6_rst_state", dbg_state, WAIT);
    @(negedge clk);
    rst_l = 1'b0;
    setup_t1();
    run_op(1'b1, cyc);
    check_t1_result("t6");
    repeat (5) @(posedge clk);
    #1;
    check("t6_hold_done", done, 1'b1);
    check("t6_hold_state", dbg_state, DONE);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("t6_release_done", done, 1'b0);
    check("t6_release_state", dbg_state, WAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
